// File: rtl/serial_add_ctrl.sv
// Multi-word adder that time-shares one external 4-bit adder (no carry-in).
// A nibble with an incoming carry costs an extra INC cycle that adds 1 to the partial sum.
module serial_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4*WORDS-1:0] op_a,
    input  logic [4*WORDS-1:0] op_b,
    output logic [3:0]         adder_a,
    output logic [3:0]         adder_b,
    input  logic [3:0]         adder_sum,
    input  logic               adder_carry,
    output logic               busy,
    output logic               done,
    output logic [4*WORDS-1:0] sum,
    output logic               carry_out,
    output logic [1:0]         dbg_state
);

    localparam int W    = 4 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        INC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            cin_q, cin_d;
    logic [3:0]      tmp_q, tmp_d;
    logic            c1_q, c1_d;
    logic            cout_q, cout_d;
    logic            step;
    logic            step_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            cin_q   <= 1'b0;
            tmp_q   <= 4'd0;
            c1_q    <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            cin_q   <= cin_d;
            tmp_q   <= tmp_d;
            c1_q    <= c1_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        cin_d   = cin_q;
        tmp_d   = tmp_q;
        c1_d    = c1_q;
        cout_d  = cout_q;
        adder_a = 4'd0;
        adder_b = 4'd0;
        step    = 1'b0;
        step_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    idx_d   = '0;
                    cin_d   = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                adder_a = a_q[{idx_q, 2'b00} +: 4];
                adder_b = b_q[{idx_q, 2'b00} +: 4];
                if (!cin_q) begin
                    sum_d[{idx_q, 2'b00} +: 4] = adder_sum;
                    step   = 1'b1;
                    step_c = adder_carry;
                end else begin
                    tmp_d   = adder_sum;
                    c1_d    = adder_carry;
                    state_d = INC;
                end
            end
            INC: begin
                adder_a = tmp_q;
                adder_b = 4'd1;
                sum_d[{idx_q, 2'b00} +: 4] = adder_sum;
                // Both carries can never be set: a nibble sum that carried is at most 0xE.
                step   = 1'b1;
                step_c = c1_q | adder_carry;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (step) begin
            cin_d = step_c;
            if (idx_q == LAST_IDX) begin
                cout_d  = step_c;
                state_d = DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ADD;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an arithmetic reference model plus a per-cycle compare process.
module tb_serial_add_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   adder_a;
    logic [3:0]   adder_b;
    logic [3:0]   adder_sum;
    logic         adder_carry;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic [1:0]   dbg_state;

    int tests;
    int fails;
    int ncnt;

    // Reference model state: expected result and the negedge index at which done must show.
    logic         m_active;
    logic         m_valid;
    int           m_done_at;
    logic [W-1:0] m_sum;
    logic         m_c;
    logic [W-1:0] exp_q[$];

    serial_add_ctrl #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_sum   (adder_sum),
        .adder_carry (adder_carry),
        .busy        (busy),
        .done        (done),
        .sum         (sum),
        .carry_out   (carry_out),
        .dbg_state   (dbg_state)
    );

    // The shared external adder.
    assign {adder_carry, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b};

    // Clock / reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result = (a+b) mod 2^W; latency = WORDS + number of nibbles receiving a carry.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] s, output logic c, output int lat);
        logic [W:0] full;
        longint unsigned mask, am, bm;
        full = {1'b0, a} + {1'b0, b};
        s    = full[W-1:0];
        c    = full[W];
        lat  = WORDS;
        for (int i = 1; i < WORDS; i++) begin
            mask = (64'd1 << (4 * i)) - 64'd1;
            am   = longint'(a) & mask;
            bm   = longint'(b) & mask;
            if ((((am + bm) >> (4 * i)) & 64'd1) != 0) lat++;
        end
    endfunction

    // Compare process: every negedge while out of reset.
    initial begin
        forever begin
            @(negedge clk);
            ncnt++;
            if (rst_n) begin
                if (m_active) begin
                    check("busy_run", {63'd0, busy}, {63'd0, (ncnt <= m_done_at)});
                    check("done_run", {63'd0, done}, {63'd0, (ncnt == m_done_at)});
                    if (ncnt == m_done_at) begin
                        m_sum = exp_q.pop_front();
                        check("sum_done", {48'd0, sum}, {48'd0, m_sum});
                        check("cout_done", {63'd0, carry_out}, {63'd0, m_c});
                        check("adder_a_done", {60'd0, adder_a}, 64'd0);
                        check("adder_b_done", {60'd0, adder_b}, 64'd0);
                        m_active = 1'b0;
                        m_valid  = 1'b1;
                    end
                end else begin
                    check("busy_idle", {63'd0, busy}, 64'd0);
                    check("done_idle", {63'd0, done}, 64'd0);
                    check("adder_idle", {56'd0, adder_a, adder_b}, 64'd0);
                    if (m_valid) begin
                        check("sum_hold", {48'd0, sum}, {48'd0, m_sum});
                        check("cout_hold", {63'd0, carry_out}, {63'd0, m_c});
                    end
                end
            end
        end
    end

    // Driver: accept one addition, optionally re-pulse start while busy, wait for done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] lit_s, input logic lit_c, input int lit_lat,
                          input int retrig);
        logic [W-1:0] s;
        logic         c;
        int           lat;
        int           count;
        model(a, b, s, c, lat);
        check("model_sum", {48'd0, s}, {48'd0, lit_s});
        check("model_lat", 64'(lat), 64'(lit_lat));
        @(negedge clk);
        #1;
        op_a      = a;
        op_b      = b;
        start     = 1'b1;
        m_done_at = ncnt + lat + 1;
        m_c       = c;
        exp_q.push_back(s);
        m_active  = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        op_a  = W'($urandom_range(0, 65535));
        op_b  = W'($urandom_range(0, 65535));
        count = 1;
        while (!done && count < 40) begin
            start = (count == retrig);
            @(negedge clk);
            #1;
            count++;
        end
        start = 1'b0;
        check("done_seen", {63'd0, done}, 64'd1);
        check("latency", 64'(count - 1), 64'(lit_lat));
        check("sum_lit", {48'd0, sum}, {48'd0, lit_s});
        check("cout_lit", {63'd0, carry_out}, {63'd0, lit_c});
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {44'd0, sum, carry_out, busy, done, adder_a, adder_b}, 64'd0);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        ncnt     = 0;
        m_active = 1'b0;
        m_valid  = 1'b0;
        m_sum    = '0;
        m_c      = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        #2;
        check_all_zero("reset_outputs");
        check("reset_state", {62'd0, dbg_state}, 64'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n   = 1'b1;
        m_valid = 1'b1;
        repeat (2) @(negedge clk);

        run_op(16'h0000, 16'h0000, 16'h0000, 1'b0, 4, 0);
        run_op(16'h0005, 16'h0005, 16'h000A, 1'b0, 4, 0);
        run_op(16'h000F, 16'h000F, 16'h001E, 1'b0, 5, 0);
        run_op(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 7, 3);
        run_op(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 7, 0);
        run_op(16'h8000, 16'h8000, 16'h0000, 1'b1, 4, 0);
        run_op(16'h0FFF, 16'h0001, 16'h1000, 1'b0, 7, 5);

        // Abort a run in its first INC cycle (third cycle after accepting 0xFFFF+0x0001).
        @(negedge clk);
        #1;
        op_a      = 16'hFFFF;
        op_b      = 16'h0001;
        start     = 1'b1;
        m_done_at = ncnt + 8;
        m_c       = 1'b1;
        exp_q.push_back(16'h0000);
        m_active  = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("inc_before_reset", {59'd0, busy, adder_b}, {59'd0, 1'b1, 4'd1});
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        m_active = 1'b0;
        exp_q.delete();
        m_sum    = '0;
        m_c      = 1'b0;
        m_valid  = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_op(16'h1234, 16'h1111, 16'h2345, 1'b0, 4, 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
